// File: rtl/acc_seq_ctrl.sv
// acc_seq_ctrl: fetch/decode/execute sequencer for the 16-bit accumulator CPU.
// Drives the datapath control word, handshakes a stalling data memory, and flags illegal opcodes and timeouts.
module acc_seq_ctrl #(
  parameter int IW       = 16,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [IW-1:0]    ir,
  input  logic             zf,
  input  logic             dm_rdy,
  output logic [7:0]       cw,
  output logic [2:0]       alu_op,
  output logic             j,
  output logic [2:0]       state,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] instr_cnt
);
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_HALT   = 3'd5
  } state_t;
  localparam int WW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [WW-1:0] W_LAST = WW'(WAIT_MAX - 1);
  localparam logic [3:0] OP_LDA = 4'h1, OP_STA = 4'h2, OP_ADD = 4'h3, OP_NOT = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8, OP_JZ = 4'h9, OP_JNZ = 4'hA, OP_HLT = 4'hF;
  state_t           r_state, w_next;
  logic [3:0]       r_op;
  logic [WW-1:0]    r_wait;
  logic             r_illegal, r_bus_err;
  logic [CNT_W-1:0] r_cnt;
  logic             w_exec, w_mem, w_memop, w_alu, w_ill, w_to, w_retire;
  logic             w_unused_ir;
  assign w_unused_ir = ^ir[IW-5:0];
  always_comb begin
    w_exec   = r_state == S_EXEC;
    w_mem    = r_state == S_MEM;
    w_memop  = r_op == OP_LDA || r_op == OP_STA;
    w_alu    = r_op >= OP_ADD && r_op <= OP_NOT;
    w_ill    = r_op >= 4'hB && r_op <= 4'hE;
    // Timeout fires on the WAIT_MAX-th consecutive stalled MEM cycle.
    w_to     = w_mem && !dm_rdy && r_wait == W_LAST;
    w_retire = (w_exec && !w_memop) || (w_mem && dm_rdy);
    cw       = '0;
    alu_op   = '0;
    w_next   = r_state;
    case (r_state)
      S_IDLE:   w_next = run ? S_FETCH : S_IDLE;
      S_FETCH: begin
        cw[7]  = 1'b1;
        cw[5]  = 1'b1;
        w_next = S_DECODE;
      end
      S_DECODE: w_next = S_EXEC;
      S_EXEC: begin
        cw[4]  = w_alu;
        alu_op = w_alu ? 3'(r_op - 4'd2) : 3'd0;
        cw[6]  = r_op == OP_JMP || (r_op == OP_JZ && zf) || (r_op == OP_JNZ && !zf);
        w_next = w_memop ? S_MEM : r_op == OP_HLT ? S_HALT : run ? S_FETCH : S_IDLE;
      end
      S_MEM: begin
        cw[1]  = r_op == OP_LDA;
        cw[2]  = r_op == OP_STA;
        cw[4]  = dm_rdy && r_op == OP_LDA;
        cw[3]  = dm_rdy && r_op == OP_LDA;
        w_next = dm_rdy ? (run ? S_FETCH : S_IDLE) : w_to ? S_HALT : S_MEM;
      end
      S_HALT:   cw[0] = 1'b1;
      default:  w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_wait    <= '0;
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_op <= ir[IW-1 -: 4];
      r_wait <= (w_mem && !dm_rdy) ? r_wait + 1'b1 : '0;
      if (w_exec && w_ill) r_illegal <= 1'b1;
      if (w_to) r_bus_err <= 1'b1;
      if (w_retire) r_cnt <= r_cnt + 1'b1;
    end
  end
  assign j         = cw[6];
  assign state     = r_state;
  assign illegal   = r_illegal;
  assign bus_err   = r_bus_err;
  assign instr_cnt = r_cnt;
endmodule

// File: tb/tb_acc_seq_ctrl.sv
// tb_acc_seq_ctrl: directed vector table plus hand-written reset, timeout and run-drop sequences.
module tb_acc_seq_ctrl;
  logic        clk = 1'b0, rst = 1'b1, run = 1'b0, zf = 1'b0, dm_rdy = 1'b0;
  logic [15:0] ir = '0;
  logic [7:0]  cw;
  logic [2:0]  alu_op, state;
  logic        j, illegal, bus_err;
  logic [15:0] instr_cnt;
  int          n_chk = 0, n_pass = 0;
  typedef struct packed {
    logic        run;
    logic [15:0] ir;
    logic        zf;
    logic        rdy;
    logic [2:0]  st;
    logic [7:0]  cw;
    logic [2:0]  alu;
    logic        j;
    logic        ill;
    logic        be;
    logic [15:0] cnt;
  } vec_t;
  vec_t tv[$];
  acc_seq_ctrl dut (
    .clk(clk), .rst(rst), .run(run), .ir(ir), .zf(zf), .dm_rdy(dm_rdy),
    .cw(cw), .alu_op(alu_op), .j(j), .state(state), .illegal(illegal),
    .bus_err(bus_err), .instr_cnt(instr_cnt)
  );
  always #5 clk = ~clk;
  task automatic add(input logic r, input logic [15:0] i, input logic z, input logic d,
                     input logic [2:0] s, input logic [7:0] c, input logic [2:0] a,
                     input logic jj, input logic il, input logic b, input logic [15:0] n);
    tv.push_back('{r, i, z, d, s, c, a, jj, il, b, n});
  endtask
  task automatic check(input string nm, input logic [2:0] s, input logic [7:0] c, input logic [2:0] a,
                       input logic jj, input logic il, input logic b, input logic [15:0] n);
    n_chk++;
    if ({state, cw, alu_op, j, illegal, bus_err, instr_cnt} === {s, c, a, jj, il, b, n}) n_pass++;
    else $display("FAIL %s: got st=%0d cw=%h alu=%b j=%b ill=%b be=%b cnt=%0d, want st=%0d cw=%h alu=%b j=%b ill=%b be=%b cnt=%0d",
                  nm, state, cw, alu_op, j, illegal, bus_err, instr_cnt, s, c, a, jj, il, b, n);
  endtask
  task automatic cyc(input logic r, input logic [15:0] i, input logic z, input logic d);
    @(negedge clk);
    run = r; ir = i; zf = z; dm_rdy = d;
    #1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    run = 1'b0; rst = 1'b1;
    #1 rst = 1'b0;
  endtask
  initial begin
    // run ir zf rdy | st cw alu j ill be cnt
    add(1, 16'h3005, 0, 1, 0, 8'h00, 3'b000, 0, 0, 0, 0);
    add(1, 16'h3005, 0, 1, 1, 8'hA0, 3'b000, 0, 0, 0, 0);
    add(1, 16'h3005, 0, 1, 2, 8'h00, 3'b000, 0, 0, 0, 0);
    add(1, 16'h3005, 0, 1, 3, 8'h10, 3'b001, 0, 0, 0, 0);
    add(1, 16'h1007, 0, 0, 1, 8'hA0, 3'b000, 0, 0, 0, 1);
    add(1, 16'h1007, 0, 0, 2, 8'h00, 3'b000, 0, 0, 0, 1);
    add(1, 16'h1007, 0, 0, 3, 8'h00, 3'b000, 0, 0, 0, 1);
    add(1, 16'h1007, 0, 0, 4, 8'h02, 3'b000, 0, 0, 0, 1);
    add(1, 16'h1007, 0, 0, 4, 8'h02, 3'b000, 0, 0, 0, 1);
    add(1, 16'h1007, 0, 1, 4, 8'h1A, 3'b000, 0, 0, 0, 1);
    add(1, 16'h9000, 1, 1, 1, 8'hA0, 3'b000, 0, 0, 0, 2);
    add(1, 16'h9000, 1, 1, 2, 8'h00, 3'b000, 0, 0, 0, 2);
    add(1, 16'h9000, 1, 1, 3, 8'h40, 3'b000, 1, 0, 0, 2);
    add(1, 16'h9000, 0, 1, 1, 8'hA0, 3'b000, 0, 0, 0, 3);
    add(1, 16'h9000, 0, 1, 2, 8'h00, 3'b000, 0, 0, 0, 3);
    add(1, 16'h9000, 0, 1, 3, 8'h00, 3'b000, 0, 0, 0, 3);
    add(1, 16'hA000, 0, 1, 1, 8'hA0, 3'b000, 0, 0, 0, 4);
    add(1, 16'hA000, 0, 1, 2, 8'h00, 3'b000, 0, 0, 0, 4);
    add(1, 16'hA000, 0, 1, 3, 8'h40, 3'b000, 1, 0, 0, 4);
    add(1, 16'hC000, 0, 1, 1, 8'hA0, 3'b000, 0, 0, 0, 5);
    add(1, 16'hC000, 0, 1, 2, 8'h00, 3'b000, 0, 0, 0, 5);
    add(1, 16'hC000, 0, 1, 3, 8'h00, 3'b000, 0, 0, 0, 5);
    add(1, 16'h4000, 0, 1, 1, 8'hA0, 3'b000, 0, 1, 0, 6);
    add(1, 16'h4000, 0, 1, 2, 8'h00, 3'b000, 0, 1, 0, 6);
    add(1, 16'h4000, 0, 1, 3, 8'h10, 3'b010, 0, 1, 0, 6);
    add(1, 16'h7000, 0, 1, 1, 8'hA0, 3'b000, 0, 1, 0, 7);
    add(1, 16'h7000, 0, 1, 2, 8'h00, 3'b000, 0, 1, 0, 7);
    add(1, 16'h7000, 0, 1, 3, 8'h10, 3'b101, 0, 1, 0, 7);
    add(1, 16'h2000, 0, 1, 1, 8'hA0, 3'b000, 0, 1, 0, 8);
    add(1, 16'h2000, 0, 1, 2, 8'h00, 3'b000, 0, 1, 0, 8);
    add(1, 16'h2000, 0, 1, 3, 8'h00, 3'b000, 0, 1, 0, 8);
    add(1, 16'h2000, 0, 1, 4, 8'h04, 3'b000, 0, 1, 0, 8);
    add(1, 16'hF000, 0, 1, 1, 8'hA0, 3'b000, 0, 1, 0, 9);
    add(1, 16'hF000, 0, 1, 2, 8'h00, 3'b000, 0, 1, 0, 9);
    add(1, 16'hF000, 0, 1, 3, 8'h00, 3'b000, 0, 1, 0, 9);
    add(0, 16'hF000, 0, 1, 5, 8'h01, 3'b000, 0, 1, 0, 10);
    add(1, 16'hF000, 0, 1, 5, 8'h01, 3'b000, 0, 1, 0, 10);
    @(negedge clk);
    #1 check("reset_state", 0, 8'h00, 3'b000, 0, 0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < tv.size(); i++) begin
      cyc(tv[i].run, tv[i].ir, tv[i].zf, tv[i].rdy);
      check($sformatf("vec%0d", i), tv[i].st, tv[i].cw, tv[i].alu, tv[i].j, tv[i].ill, tv[i].be, tv[i].cnt);
    end
    // STA timeout: fifteen stalled MEM cycles then bus error and HALT
    do_reset();
    repeat (5) cyc(1, 16'h2000, 0, 0);
    check("sta_mem_first", 4, 8'h04, 3'b000, 0, 0, 0, 0);
    repeat (14) cyc(1, 16'h2000, 0, 0);
    check("sta_mem_last", 4, 8'h04, 3'b000, 0, 0, 0, 0);
    cyc(1, 16'h2000, 0, 0);
    check("bus_err_halt", 5, 8'h01, 3'b000, 0, 0, 1, 0);
    cyc(0, 16'h2000, 0, 1);
    check("halt_run0", 5, 8'h01, 3'b000, 0, 0, 1, 0);
    cyc(1, 16'h3005, 0, 1);
    check("halt_run1", 5, 8'h01, 3'b000, 0, 0, 1, 0);
    // asynchronous reset in the middle of a stalled STA
    do_reset();
    repeat (4) cyc(1, 16'hC000, 0, 0);
    repeat (5) cyc(1, 16'h2000, 0, 0);
    check("pre_rst_mem", 4, 8'h04, 3'b000, 0, 1, 0, 1);
    rst = 1'b1;
    #1 check("rst_mid_mem", 0, 8'h00, 3'b000, 0, 0, 0, 0);
    rst = 1'b0; run = 1'b0;
    // run dropped during EXEC still completes the instruction
    do_reset();
    repeat (3) cyc(1, 16'h3005, 0, 1);
    cyc(0, 16'h3005, 0, 1);
    check("drop_exec", 3, 8'h10, 3'b001, 0, 0, 0, 0);
    cyc(0, 16'h3005, 0, 1);
    check("drop_idle", 0, 8'h00, 3'b000, 0, 0, 0, 1);
    cyc(0, 16'h3005, 0, 1);
    check("drop_park", 0, 8'h00, 3'b000, 0, 0, 0, 1);
    // LDA with zero wait: load in the first MEM cycle
    do_reset();
    repeat (4) cyc(1, 16'h1007, 0, 1);
    cyc(1, 16'h1007, 0, 1);
    check("lda_zero_wait", 4, 8'h1A, 3'b000, 0, 0, 0, 0);
    cyc(1, 16'h0000, 0, 1);
    check("lda_retired", 1, 8'hA0, 3'b000, 0, 0, 0, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
